alu_seq: RTL
============

# alu_seq

Parametrised, registered successor to the single-cycle datapath ALU. It keeps the same operand-source muxing (SrcA/SrcB) and the base ops (and, or, add, sub, slt, sgt, seq), and adds iterative shifts and an optional iterative multiplier. A start/busy/valid handshake lets the control FSM stall while a multi-cycle op runs. It sits between the register block and the writeback mux.

## Interface
Parameters:
- WIDTH, 16, datapath width in bits (≥8, power of two)

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  request an operation; accepted only when busy==0
- AluOp  in  4  operation select (see Operation)
- SrcA  in  1  A select: 0 = mary, 1 = sp
- SrcB  in  2  B select: 00 = shelley, 01 = zext_imm, 10 = sext_imm, 11 = sext_ls_imm
- mary, sp, shelley, zext_imm, sext_imm, sext_ls_imm  in  WIDTH  operand sources
- out  out  WIDTH  registered result; holds its value until the next completion
- Overflow  out  1  registered overflow flag; updated with out
- valid  out  1  one-cycle pulse on the cycle out/Overflow update
- busy  out  1  high while a multi-cycle op is in flight

## Operation
- On an accepted start, A and B are muxed and captured into internal registers. Later source changes do not affect the op.
- AluOp encodings and results:
  - 0000 and: A&B
  - 0001 or: A|B
  - 0010 add: A+B (mod 2^WIDTH)
  - 0011 sub: A−B
  - 0100 slt: signed A<B → 1, else 0
  - 0101 sgt: signed A>B → 1, else 0
  - 0110 seq: A==B → 1, else 0
  - 0111 sll: A<<shamt
  - 1000 srl: A>>shamt (logical)
  - 1001 sra: A>>>shamt (arithmetic)
  - 1010 mul: low WIDTH bits of unsigned A*B
  - 1011–1111 illegal: out=0, Overflow=0
- Shift amount: shamt = B[log2(WIDTH)−1:0]; upper bits of B are ignored.
- Overflow rules:
  - add/sub: signed two's-complement overflow.
  - mul: 1 if the upper WIDTH bits of the 2·WIDTH product are nonzero.
  - All other ops: 0.
- States:
  - IDLE: busy=0.
  - RUN: busy=1. Holds a shift/step counter.
  - IDLE → RUN on an accepted iterative op needing more than 1 cycle.
  - RUN → IDLE on the final step. The result is written and valid pulses on that edge.
- Shifts: one bit position per cycle.
- mul: shift-add, one multiplier bit per cycle, WIDTH steps.

## Timing
Start accepted on the edge ending cycle N:
- Base ops, illegal ops, shifts with shamt ≤ 1: out/valid at N+1; busy never asserts.
- Shifts with shamt=k>1: busy=1 in cycles N+1..N+k−1; out/valid at N+k, with busy=0 in that cycle.
- mul: busy=1 in N+1..N+WIDTH−1; out/valid at N+WIDTH.

Handshake rules:
- start while busy=1 is ignored: no capture, no extra valid.
- A start in the same cycle as a valid pulse (busy=0) is accepted, so back-to-back ops run with zero bubble.

Reset values: out=0, Overflow=0, valid=0, busy=0, state=IDLE, counters=0.
- Reset mid-op aborts the op: the next cycle is IDLE and no valid pulse is ever produced for the aborted op.
- reset and start in the same cycle: reset wins.

## Configuration
- ALU_MUL_EN defined: the iterative multiplier is compiled in and op 1010 behaves as specified.
- ALU_MUL_EN undefined: multiplier logic is absent. 1010 is treated as illegal: out=0, Overflow=0, valid at N+1, busy never asserts.

## Test plan
All scenarios use WIDTH=16, mary=57, sp=62, zext_imm=80, sext_imm=34, sext_ls_imm=136.
- SrcA=0, SrcB=10, AluOp=0010 → out=91, Overflow=0, valid at N+1. SrcB=01, AluOp=0000 → out=16. SrcB=00 (shelley=75), AluOp=0011 → out=0xFFEE (−18).
- mary=0x7FFF, shelley=1, SrcB=00, add → out=0x8000, Overflow=1. Then slt (shelley=75, mary=57) → 1, sgt → 0, seq → 0. With shelley=57, seq → 1.
- shelley=3, SrcB=00, sll → busy high N+1..N+2, out=456, valid at N+3. sra with mary=0x8000, shelley=4 → out=0xF800.
- ALU_MUL_EN set, mul 57×75 → out=4275, Overflow=0, valid at N+16. Then mary=300, shelley=300 → out=24464, Overflow=1. start pulsed at N+5 during a mul → ignored, exactly one valid.
- reset asserted at cycle N+5 of a mul → at N+6 busy=0, valid=0, out=0; no valid through N+20.
- ALU_MUL_EN unset, AluOp=1010 or 1111 → out=0, Overflow=0, valid at N+1, busy never high.

Source files
------------

// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq : registered, multi-cycle ALU between the register block and the
//           writeback mux.
//
// Operands are muxed from the source buses and captured when a request is
// accepted. Logic ops, add/sub and compares finish in one cycle. Shifts move
// one bit position per cycle. The optional multiplier does shift-add, one
// multiplier bit per cycle, for WIDTH steps. Busy tells the control FSM to
// stall.
//
// Configuration macro:
//   ALU_MUL_EN  defined   -> iterative multiplier built in; op 1010 = mul
//               undefined -> no multiplier logic; op 1010 is treated as illegal
//
// Parameters:
//   WIDTH        datapath width in bits (>= 8, power of two)
//
// Ports:
//   clock        rising-edge clock
//   reset        synchronous, active-high reset
//   start        operation request; accepted only while busy == 0
//   AluOp[3:0]   operation select
//   SrcA         A select: 0 = mary, 1 = sp
//   SrcB[1:0]    B select: shelley / zext_imm / sext_imm / sext_ls_imm
//   mary, sp, shelley, zext_imm, sext_imm, sext_ls_imm   operand sources
//   out          registered result; held until the next completion
//   Overflow     registered overflow flag; updated together with out
//   valid        one-cycle pulse in the cycle out/Overflow change
//   busy         high while a multi-cycle op is in flight
// -----------------------------------------------------------------------------
module alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       AluOp,
  input  logic             SrcA,
  input  logic [1:0]       SrcB,
  input  logic [WIDTH-1:0] mary,
  input  logic [WIDTH-1:0] sp,
  input  logic [WIDTH-1:0] shelley,
  input  logic [WIDTH-1:0] zext_imm,
  input  logic [WIDTH-1:0] sext_imm,
  input  logic [WIDTH-1:0] sext_ls_imm,
  output logic [WIDTH-1:0] out,
  output logic             Overflow,
  output logic             valid,
  output logic             busy
);

  localparam int SHW = $clog2(WIDTH);  // shift-amount width
  localparam int CW  = SHW + 1;        // step counter must reach WIDTH-1

  typedef enum logic [3:0] {
    OP_AND = 4'b0000,
    OP_OR  = 4'b0001,
    OP_ADD = 4'b0010,
    OP_SUB = 4'b0011,
    OP_SLT = 4'b0100,
    OP_SGT = 4'b0101,
    OP_SEQ = 4'b0110,
    OP_SLL = 4'b0111,
    OP_SRL = 4'b1000,
    OP_SRA = 4'b1001,
    OP_MUL = 4'b1010
  } alu_op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_e           state_q, state_d;
  alu_op_e          op_q, op_d;
  logic [WIDTH-1:0] sh_q, sh_d;       // partially shifted operand
  logic [CW-1:0]    cnt_q, cnt_d;     // steps still to run in S_RUN
  logic [WIDTH-1:0] out_q, out_d;
  logic             ovf_q, ovf_d;
  logic             valid_q, valid_d;

`ifdef ALU_MUL_EN
  logic [2*WIDTH-1:0] mcand_q, mcand_d;   // multiplicand, pre-shifted per step
  logic [WIDTH-1:0]   mplier_q, mplier_d; // multiplier, consumed LSB first
  logic [2*WIDTH-1:0] prod_q, prod_d;     // full-width partial product
  logic [2*WIDTH-1:0] prod_step;
`endif

  // ---------------------------------------------------------------------------
  // Operand selection and request decode
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] a_mux, b_mux;
  alu_op_e          op_in;
  logic [SHW-1:0]   shamt;
  logic             accept;
  logic             is_shift_in;
  logic             launch_run;
  logic             last_step;

  always_comb begin
    a_mux = SrcA ? sp : mary;
    case (SrcB)
      2'b00:   b_mux = shelley;
      2'b01:   b_mux = zext_imm;
      2'b10:   b_mux = sext_imm;
      default: b_mux = sext_ls_imm;
    endcase
  end

  assign op_in       = alu_op_e'(AluOp);
  assign shamt       = b_mux[SHW-1:0];
  assign accept      = start && (state_q == S_IDLE);
  assign is_shift_in = (op_in == OP_SLL) || (op_in == OP_SRL) || (op_in == OP_SRA);
  assign last_step   = (cnt_q == CW'(1));

  // The first step of every iterative op happens on the accepting edge, so
  // only ops needing two or more steps ever enter S_RUN.
`ifdef ALU_MUL_EN
  assign launch_run = accept && ((is_shift_in && (shamt > SHW'(1))) || (op_in == OP_MUL));
`else
  assign launch_run = accept && is_shift_in && (shamt > SHW'(1));
`endif

  // One bit position of the selected shift.
  function automatic logic [WIDTH-1:0] shift1(input logic [WIDTH-1:0] v,
                                              input alu_op_e          op);
    case (op)
      OP_SLL:  shift1 = {v[WIDTH-2:0], 1'b0};
      OP_SRL:  shift1 = {1'b0, v[WIDTH-1:1]};
      default: shift1 = {v[WIDTH-1], v[WIDTH-1:1]};
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Single-cycle ops
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] sum, diff;
  logic [WIDTH-1:0] base_res;
  logic             base_ovf;

  assign sum  = a_mux + b_mux;
  assign diff = a_mux - b_mux;

  always_comb begin
    base_res = '0;
    base_ovf = 1'b0;
    case (op_in)
      OP_AND: base_res = a_mux & b_mux;
      OP_OR:  base_res = a_mux | b_mux;
      OP_ADD: begin
        base_res = sum;
        // Like-signed operands whose sum flips sign.
        base_ovf = (a_mux[WIDTH-1] == b_mux[WIDTH-1]) && (sum[WIDTH-1] != a_mux[WIDTH-1]);
      end
      OP_SUB: begin
        base_res = diff;
        // Unlike-signed operands whose difference takes B's sign.
        base_ovf = (a_mux[WIDTH-1] != b_mux[WIDTH-1]) && (diff[WIDTH-1] != a_mux[WIDTH-1]);
      end
      OP_SLT:  base_res = WIDTH'($signed(a_mux) < $signed(b_mux));
      OP_SGT:  base_res = WIDTH'($signed(a_mux) > $signed(b_mux));
      OP_SEQ:  base_res = WIDTH'(a_mux == b_mux);
      default: base_res = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: state register / next state / outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    // NOTE: registers take non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    // NOTE: a default on entry to every always_comb keeps each path assigned,
    // so no latch is inferred.
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (launch_run) state_d = S_RUN;
      S_RUN:   if (last_step)  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == S_RUN);
  end

  // ---------------------------------------------------------------------------
  // Datapath next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    op_d    = op_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    ovf_d   = ovf_q;
    valid_d = 1'b0;
`ifdef ALU_MUL_EN
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    prod_d    = prod_q;
    prod_step = prod_q + (mplier_q[0] ? mcand_q : '0);
`endif

    if (accept) begin
      op_d  = op_in;
      cnt_d = '0;
      case (op_in)
        OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_SGT, OP_SEQ: begin
          out_d   = base_res;
          ovf_d   = base_ovf;
          valid_d = 1'b1;
        end
        OP_SLL, OP_SRL, OP_SRA: begin
          if (shamt == '0) begin
            out_d   = a_mux;
            ovf_d   = 1'b0;
            valid_d = 1'b1;
          end else if (shamt == SHW'(1)) begin
            out_d   = shift1(a_mux, op_in);
            ovf_d   = 1'b0;
            valid_d = 1'b1;
          end else begin
            sh_d  = shift1(a_mux, op_in);
            cnt_d = {1'b0, shamt} - CW'(1);
          end
        end
`ifdef ALU_MUL_EN
        OP_MUL: begin
          // Step for multiplier bit 0 happens here; WIDTH-1 steps remain.
          prod_d   = b_mux[0] ? {{WIDTH{1'b0}}, a_mux} : '0;
          mcand_d  = {{(WIDTH-1){1'b0}}, a_mux, 1'b0};
          mplier_d = {1'b0, b_mux[WIDTH-1:1]};
          cnt_d    = CW'(WIDTH - 1);
        end
`endif
        default: begin
          out_d   = '0;
          ovf_d   = 1'b0;
          valid_d = 1'b1;
        end
      endcase
    end else if (state_q == S_RUN) begin
      cnt_d = cnt_q - CW'(1);
`ifdef ALU_MUL_EN
      if (op_q == OP_MUL) begin
        prod_d   = prod_step;
        mcand_d  = {mcand_q[2*WIDTH-2:0], 1'b0};
        mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
        if (last_step) begin
          out_d   = prod_step[WIDTH-1:0];
          ovf_d   = |prod_step[2*WIDTH-1:WIDTH];
          valid_d = 1'b1;
        end
      end else
`endif
      begin
        sh_d = shift1(sh_q, op_q);
        if (last_step) begin
          out_d   = shift1(sh_q, op_q);
          ovf_d   = 1'b0;
          valid_d = 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    // NOTE: the operand and step registers are reset too, so an op aborted by
    // reset leaves nothing behind that could later surface as a result.
    if (reset) begin
      op_q     <= OP_AND;
      sh_q     <= '0;
      cnt_q    <= '0;
      out_q    <= '0;
      ovf_q    <= 1'b0;
      valid_q  <= 1'b0;
`ifdef ALU_MUL_EN
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
`endif
    end else begin
      op_q     <= op_d;
      sh_q     <= sh_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      ovf_q    <= ovf_d;
      valid_q  <= valid_d;
`ifdef ALU_MUL_EN
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
`endif
    end
  end

  assign out      = out_q;
  assign Overflow = ovf_q;
  assign valid    = valid_q;

endmodule
